// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator: counters, syncs, blanks and line/frame strobes.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit registered frame counter output.
module vga_timing_gen #(
   parameter int unsigned CW        = 11,
   parameter int unsigned H_ACTIVE  = 800,
   parameter int unsigned H_FP      = 40,
   parameter int unsigned H_SYNC    = 128,
   parameter int unsigned H_BP      = 88,
   parameter int unsigned V_ACTIVE  = 600,
   parameter int unsigned V_FP      = 1,
   parameter int unsigned V_SYNC    = 4,
   parameter int unsigned V_BP      = 23,
   parameter int unsigned HSYNC_POL = 1,
   parameter int unsigned VSYNC_POL = 1
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          ce,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          hsync,
   output logic          vsync,
   output logic          hblnk,
   output logic          vblnk,
   output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic          frame_start,
   output logic [15:0]   frame_cnt
`else
   output logic          frame_start
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if ((H_TOTAL > (2 ** CW)) || (V_TOTAL > (2 ** CW))) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
   end

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);

   // Sync window bounds carry one extra bit so an end equal to 2^CW cannot alias to zero.
   localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic HS_ON = (HSYNC_POL != 0);
   localparam logic VS_ON = (VSYNC_POL != 0);

   logic          h_wrap;
   logic          v_wrap;
   logic [CW-1:0] h_next;
   logic [CW-1:0] v_next;
   logic          hs_next;
   logic          vs_next;

   always_comb begin
      h_wrap  = (hcount == H_LAST);
      v_wrap  = (vcount == V_LAST);
      h_next  = h_wrap ? '0 : hcount + CW'(1);
      v_next  = vcount;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : vcount + CW'(1);
      end
      hs_next = ({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END);
      vs_next = ({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END);
   end

   // Status outputs are decoded from the next count so they line up with the registered counters.
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount      <= '0;
         vcount      <= '0;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (ce) begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= hs_next ? HS_ON : ~HS_ON;
            vsync       <= vs_next ? VS_ON : ~VS_ON;
            hblnk       <= (h_next >= H_ACT);
            vblnk       <= (v_next >= V_ACT);
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
         end
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (ce && h_wrap && v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: vector table on an SVGA-default instance, plus a whole-frame walk
// of a tiny active-low-sync instance with gated enable.
module tb_vga_timing_gen;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Instance A: default 800x600 mode, active-high syncs
   logic        rst_a = 1'b1;
   logic        ce_a  = 1'b0;
   logic [10:0] hcount_a, vcount_a;
   logic        hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a;

   // Instance B: 8x4 visible, totals 15x8, active-low syncs
   logic        rst_b = 1'b1;
   logic        ce_b  = 1'b0;
   logic [3:0]  hcount_b, vcount_b;
   logic        hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b;

   int checkCount = 0;
   int passCount  = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fcnt_a, fcnt_b;
`endif

   vga_timing_gen dut_a (
      .pclk(pclk), .rst(rst_a), .ce(ce_a),
      .hcount(hcount_a), .vcount(vcount_a),
      .hsync(hsync_a), .vsync(vsync_a), .hblnk(hblnk_a), .vblnk(vblnk_a),
      .line_start(ls_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_start(fs_a), .frame_cnt(fcnt_a)
`else
      .frame_start(fs_a)
`endif
   );

   vga_timing_gen #(
      .CW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HSYNC_POL(0), .VSYNC_POL(0)
   ) dut_b (
      .pclk(pclk), .rst(rst_b), .ce(ce_b),
      .hcount(hcount_b), .vcount(vcount_b),
      .hsync(hsync_b), .vsync(vsync_b), .hblnk(hblnk_b), .vblnk(vblnk_b),
      .line_start(ls_b),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_start(fs_b), .frame_cnt(fcnt_b)
`else
      .frame_start(fs_b)
`endif
   );

   typedef struct {
      logic        rst;
      logic        ce;
      int          n;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        ls;
      logic        fs;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(logic r, logic c, int n, int h, int v,
                                  logic hs, logic hb, logic ls, logic fs);
      vec_t t;
      t.rst = r;  t.ce = c;  t.n = n;
      t.h = 11'(h);  t.v = 11'(v);
      t.hs = hs;  t.vs = 1'b0;  t.hb = hb;  t.vb = 1'b0;
      t.ls = ls;  t.fs = fs;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge, outputs are sampled at the same point.
   task automatic applyStimulus(input logic r, input logic c, input int n);
      rst_a = r;
      ce_a  = c;
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic stepB(input logic r, input logic c);
      rst_b = r;
      ce_b  = c;
      @(posedge pclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int adv;
      int p, h, v;
      int frames;
      logic [63:0] expB;

      // rst, ce, edges, hcount, vcount, hsync, hblnk, line_start, frame_start
      vecs.push_back(mkVec(1, 1,    3,    0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,  799,  799, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,  800, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,   39,  839, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,  840, 0, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,  127,  967, 0, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,  968, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,   87, 1055, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,    0, 1, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 1,    1,    1, 1, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1, 1053, 1054, 1, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,    1, 1055, 1, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 0,    5, 1055, 1, 0, 1, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,    0, 2, 0, 0, 1, 0));
      vecs.push_back(mkVec(0, 0,    3,    0, 2, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,    1, 2, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,  499,  500, 2, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 1,    1,    0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,    1,    1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 1,    9,   10, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 0,    1,    0, 0, 0, 0, 0, 0));

      $display("[TB] instance A: %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ce, vecs[i].n);
         checkOutput($sformatf("vecA%0d", i),
            64'({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a}),
            64'({vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].hb, vecs[i].vb,
                 vecs[i].ls, vecs[i].fs}));
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      checkOutput("fcntA_reset", 64'(fcnt_a), 64'd0);
`endif

      // Instance B: reset state shows inactive (high) syncs
      $display("[TB] instance B: three frames with periodic ce gaps");
      stepB(1'b1, 1'b1);
      stepB(1'b1, 1'b0);
      checkOutput("resetB",
         64'({hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b}),
         64'({4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

      // Position is tracked as a flat enabled-edge count and decoded into raster terms.
      adv    = 0;
      frames = 0;
      for (int i = 0; i < 420; i++) begin
         logic c;
         logic eLs, eFs;
         c = ((i % 7) != 3);
         stepB(1'b0, c);
         eLs = 1'b0;
         eFs = 1'b0;
         if (c) begin
            adv++;
            eLs = ((adv % 15) == 0);
            eFs = ((adv % 120) == 0);
            if (eFs) frames++;
         end
         p = adv % 120;
         h = p % 15;
         v = p / 15;
         expB = 64'({4'(h), 4'(v),
                     !((h >= 10) && (h < 13)),
                     !((v >= 5) && (v < 7)),
                     (h >= 8), (v >= 4), eLs, eFs});
         checkOutput($sformatf("frameB_edge%0d", i),
            64'({hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b}), expB);
`ifdef VGA_TIMING_FRAME_CNT_EN
         checkOutput($sformatf("fcntB_edge%0d", i), 64'(fcnt_b), 64'(frames));
`endif
      end
      checkOutput("framesB_total", 64'(frames), 64'd3);
`ifdef VGA_TIMING_FRAME_CNT_EN
      checkOutput("fcntB_final", 64'(fcnt_b), 64'd3);
`endif

      // Held-off enable after the final frame start must drop the strobes immediately
      stepB(1'b0, 1'b0);
      checkOutput("strobeB_drop", 64'({ls_b, fs_b, hcount_b, vcount_b}), 64'({1'b0, 1'b0, 4'd0, 4'd0}));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/VESA raster timing generator.
- Produces pixel and line counters, sync and blanking signals, and frame/line start strobes for any mode given by its porch/sync/active parameters.
- Sits at the head of the video pipeline; drawing and overlay stages consume its outputs on the same pclk.
- Adds features earlier timing blocks lack: reset, pixel-clock enable, programmable sync polarity, and start-of-line/start-of-frame strobes.

Parameters:
- CW, 11, bit width of hcount/vcount; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL).
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 40, horizontal front porch (pixels).
- H_SYNC, 128, horizontal sync width (pixels).
- H_BP, 88, horizontal back porch (pixels).
- V_ACTIVE, 600, visible lines per frame.
- V_FP, 1, vertical front porch (lines).
- V_SYNC, 4, vertical sync width (lines).
- V_BP, 23, vertical back porch (lines).
- HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low.
- VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low.
- Derived constants: H_TOTAL = sum of the four H values (1056 by default); V_TOTAL = sum of the four V values (628 by default).

Ports:
- pclk  in  1  pixel clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  pixel enable; the counters advance only when ce=1.
- hcount  out  CW  current pixel column, 0..H_TOTAL-1.
- vcount  out  CW  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync at HSYNC_POL level.
- vsync  out  1  vertical sync at VSYNC_POL level.
- hblnk  out  1  1 outside the horizontal active region.
- vblnk  out  1  1 outside the vertical active region.
- line_start  out  1  one-pclk strobe on entry to hcount=0.
- frame_start  out  1  one-pclk strobe on entry to hcount=0, vcount=0.

Behaviour:
- Interface: one clock, pclk; reset rst is synchronous and active-high. No asynchronous logic.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset (rst=1 at a pclk edge):
  - hcount=0, vcount=0, hblnk=0, vblnk=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0.
  - rst overrides ce. Reset mid-frame restarts at (0,0) on the next edge without a strobe.
- Counting, on an edge with ce=1:
  - If hcount<H_TOTAL-1: hcount+1.
  - Else hcount=0, and vcount advances: vcount+1, or 0 if vcount=V_TOTAL-1.
- ce=0: every output holds its value, except line_start and frame_start, which are forced to 0.
- Decode: all status outputs are registered in the same edge as the counters and match the new count values.
  - hblnk = (hcount >= H_ACTIVE).
  - hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vblnk = (vcount >= V_ACTIVE).
  - vsync active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
  - vsync and vblnk change only in the cycle where hcount becomes 0.
- Strobes:
  - line_start=1 for exactly the pclk cycle after an edge where hcount wraps to 0.
  - frame_start=1 when vcount also wraps to 0; it is coincident with line_start.
  - A held ce=0 never stretches a strobe.
- Arithmetic: all compares are unsigned at CW bits, and there is no overflow by construction. If H_TOTAL or V_TOTAL exceeds 2^CW, elaboration fails with $error.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (16 bits, out).
  - Reset value 0; increments by 1 on each frame_start.
  - Wraps 65535 -> 0.
  - Is registered and updates in the same edge that raises frame_start.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, defaults, ce=1: assert rst for 3 edges, then release -> hcount=0, vcount=0, hsync=0, vsync=0, blanks 0. hcount reaches 799 with hblnk=0, then 800 with hblnk=1. hsync rises at hcount=840 and falls at 968. hcount wraps 1055 -> 0 with vcount 0 -> 1 and line_start pulsed for 1 cycle.
2. Full frame: run 1056*628 enabled cycles -> vblnk rises at vcount=600. vsync is high for vcount 601..604. frame_start pulses once, exactly at the wrap to (0,0) after 663168 cycles.
3. ce gating: drive ce=0 for 5 cycles at hcount=1055 -> outputs frozen with no strobe. On the next ce=1 edge: hcount=0, vcount+1, line_start=1 for 1 cycle only.
4. Polarity and size: HSYNC_POL=0, VSYNC_POL=0, 640x480 (H 16/96/48, V 10/2/33) -> hsync low for hcount 656..751. vsync low for vcount 490..491. Totals 800x525.
5. Mid-frame reset: rst=1 for 1 edge at hcount=500, vcount=300 -> next edge gives (0,0) with no strobes. Counting resumes normally.
6. With VGA_TIMING_FRAME_CNT_EN defined: run 3 frames -> frame_cnt=3. Preload via 65536 frames (or force) -> wraps to 0.
